// File: rtl/country_vehicle_sensor.sv
// -----------------------------------------------------------------------------
// country_vehicle_sensor
//
// Vehicle-detection front end for the highway/country intersection. It turns
// the raw inductive-loop signal into debounced car arrivals, keeps a count of
// queued country-road cars, retires one car per DEPART_CYCLES of continuous
// country GREEN, and drives the controller's car-waiting input `x`.
//
// Ports:
//   clock        system clock, all state changes on posedge
//   clear        synchronous active-low reset
//   loop_in      raw loop detector, 1 = metal present
//   country[1:0] country light: 0 RED, 1 YELLOW, 2 GREEN, 3 invalid
//   x            registered, 1 = at least one car queued
//   queue_count  registered queued-car count (saturates at MAX_CARS)
//   arrive       one-cycle pulse when an arrival is counted
//   depart       one-cycle pulse when a car is retired
//   overflow     sticky, an arrival was dropped at saturation
//   light_err    sticky, `country` was sampled as 3
//
// Build option:
//   SENSOR_SYNC_EN  when defined, loop_in passes through a 2-flop
//                   synchronizer (reset to 0) ahead of the detector FSM,
//                   adding exactly 2 cycles of arrival latency.
// -----------------------------------------------------------------------------
module country_vehicle_sensor #(
  parameter int DEBOUNCE      = 3,   // 1..15
  parameter int MAX_CARS      = 15,  // must fit in CNT_W
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 4    // 1..15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_in,
  input  logic [1:0]       country,
  output logic             x,
  output logic [CNT_W-1:0] queue_count,
  output logic             arrive,
  output logic             depart,
  output logic             overflow,
  output logic             light_err
);

  // Detector FSM encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] QUAL_ON  = 2'd1;
  localparam logic [1:0] OCCUPIED = 2'd2;
  localparam logic [1:0] QUAL_OFF = 2'd3;

  localparam logic [1:0] GREEN   = 2'd2;
  localparam logic [1:0] INVALID = 2'd3;

  // Qualification completes on the sample that would make the count reach
  // DEBOUNCE, i.e. when the stored count already equals DEBOUNCE-1.
  localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0]       DEP_LAST = 4'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_Q    = CNT_W'(MAX_CARS);

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
  logic loop_s;

`ifdef SENSOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!clear) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], loop_in};
  end

  assign loop_s = sync_q[1];
`else
  assign loop_s = loop_in;
`endif

  // ---------------------------------------------------------------------------
  // Detector FSM: qualifies DEBOUNCE consecutive highs as one arrival and
  // DEBOUNCE consecutive lows as the car leaving the loop.
  // ---------------------------------------------------------------------------
  logic [1:0] state, state_nxt;
  logic [3:0] deb_cnt, deb_nxt;
  logic       arrival;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt = state;
    deb_nxt   = deb_cnt;
    arrival   = 1'b0;
    case (state)
      IDLE: begin
        if (loop_s) begin
          if (DEB_LAST == 4'd0) begin
            state_nxt = OCCUPIED;
            deb_nxt   = 4'd0;
            arrival   = 1'b1;
          end else begin
            state_nxt = QUAL_ON;
            deb_nxt   = 4'd1;
          end
        end
      end
      QUAL_ON: begin
        if (!loop_s) begin
          state_nxt = IDLE;
          deb_nxt   = 4'd0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = OCCUPIED;
          deb_nxt   = 4'd0;
          arrival   = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
      OCCUPIED: begin
        // A car parked on the loop stays here; it was counted once on entry.
        if (!loop_s) begin
          state_nxt = (DEB_LAST == 4'd0) ? IDLE : QUAL_OFF;
          deb_nxt   = (DEB_LAST == 4'd0) ? 4'd0 : 4'd1;
        end
      end
      default: begin  // QUAL_OFF
        if (loop_s) begin
          state_nxt = OCCUPIED;
          deb_nxt   = 4'd0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
          deb_nxt   = 4'd0;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Departure timer: runs only on continuous GREEN with cars queued; an
  // invalid colour is treated as RED, so it also clears the timer.
  // ---------------------------------------------------------------------------
  logic [3:0] dep_timer, dep_timer_nxt;
  logic       retire;
  logic       green;
  logic       has_cars;

  assign green    = (country == GREEN);
  assign has_cars = (queue_count != '0);

  always_comb begin
    dep_timer_nxt = 4'd0;
    retire        = 1'b0;
    if (green && has_cars) begin
      if (dep_timer == DEP_LAST) retire = 1'b1;
      else                       dep_timer_nxt = dep_timer + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue count. A simultaneous arrival and departure cancel, so the arrival
  // is accepted even at saturation; only an arrival alone at MAX_CARS drops.
  // retire is never raised at count 0, so the decrement cannot underflow.
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;

  assign accept = arrival && (retire || (queue_count != MAX_Q));
  assign drop   = arrival && !accept;

  always_comb begin
    count_nxt = queue_count;
    if (accept && !retire)       count_nxt = queue_count + 1'b1;
    else if (retire && !arrival) count_nxt = queue_count - 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so ordering of these statements does not matter.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= IDLE;
      deb_cnt     <= 4'd0;
      dep_timer   <= 4'd0;
      queue_count <= '0;
      x           <= 1'b0;
      arrive      <= 1'b0;
      depart      <= 1'b0;
      overflow    <= 1'b0;
      light_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      dep_timer   <= dep_timer_nxt;
      queue_count <= count_nxt;
      x           <= (count_nxt != '0);
      arrive      <= accept;
      depart      <= retire;
      if (drop)               overflow  <= 1'b1;
      if (country == INVALID) light_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_country_vehicle_sensor.sv
// -----------------------------------------------------------------------------
// tb_country_vehicle_sensor
//
// Directed bench for country_vehicle_sensor (default parameters). Stimulus
// pushes each expected arrive/depart event (with the cycle it must occur on)
// into a queue; a monitor pops and compares whenever the DUT pulses arrive or
// depart. Steady-state values are checked directly from the stimulus.
// Define SENSOR_SYNC_EN for both DUT and bench to exercise the synchronizer.
// -----------------------------------------------------------------------------
module tb_country_vehicle_sensor;

`ifdef SENSOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BAD    = 2'd3;

  logic       clock;
  logic       clear;
  logic       loop_in;
  logic [1:0] country;
  logic       x;
  logic [3:0] queue_count;
  logic       arrive;
  logic       depart;
  logic       overflow;
  logic       light_err;

  country_vehicle_sensor dut (
    .clock       (clock),
    .clear       (clear),
    .loop_in     (loop_in),
    .country     (country),
    .x           (x),
    .queue_count (queue_count),
    .arrive      (arrive),
    .depart      (depart),
    .overflow    (overflow),
    .light_err   (light_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       a;
    logic       d;
    logic [3:0] cnt;
    logic       x;
    logic       ovf;
  } evt_t;

  evt_t sb_q[$];
  evt_t mon_e;

  int n_checks = 0;
  int n_err    = 0;
  int m_cnt    = 0;
  logic m_ovf  = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(int c, logic a, logic d, int cnt, logic ovf);
    evt_t e;
    e.cyc = c;
    e.a   = a;
    e.d   = d;
    e.cnt = cnt[3:0];
    e.x   = (cnt != 0);
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // One clean car: three highs then enough lows to return to IDLE.
  task automatic car();
    if (m_cnt < 15) begin
      m_cnt++;
      push(cyc + 3 + LAT, 1'b1, 1'b0, m_cnt, m_ovf);
    end else begin
      m_ovf = 1'b1;
    end
    loop_in = 1'b1;
    repeat (3) step();
    loop_in = 1'b0;
    repeat (4 + LAT) step();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_x"},         x,           0);
    check({tag, "_count"},     queue_count, 0);
    check({tag, "_arrive"},    arrive,      0);
    check({tag, "_depart"},    depart,      0);
    check({tag, "_overflow"},  overflow,    0);
    check({tag, "_light_err"}, light_err,   0);
  endtask

  // Monitor: every pulse must match the next expected event, including when.
  always @(negedge clock) begin
    if (arrive === 1'b1 || depart === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pulse: arrive=%0b depart=%0b at cycle %0d, none expected",
                 arrive, depart, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("evt_cycle",    cyc,         mon_e.cyc);
        check("evt_arrive",   arrive,      mon_e.a);
        check("evt_depart",   depart,      mon_e.d);
        check("evt_count",    queue_count, mon_e.cnt);
        check("evt_x",        x,           mon_e.x);
        check("evt_overflow", overflow,    mon_e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int b;

    // Reset then idle
    clear   = 1'b0;
    loop_in = 1'b0;
    country = RED;
    step();
    step();
    check_all_zero("rst");
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_x", x, 0);
      check("idle_count", queue_count, 0);
    end
    check_all_zero("idle_end");

    // Debounce: two highs are not a car
    loop_in = 1'b1;
    step();
    step();
    loop_in = 1'b0;
    repeat (4 + LAT) step();
    check("deb_short_count", queue_count, 0);

    // Three highs: arrival on the third sampling edge, then a long hold
    m_cnt = 1;
    push(cyc + 3 + LAT, 1'b1, 1'b0, 1, 1'b0);
    loop_in = 1'b1;
    repeat (3 + LAT) step();
    check("deb_count", queue_count, 1);
    check("deb_x", x, 1);
    repeat (20) step();
    check("hold_count", queue_count, 1);
    loop_in = 1'b0;
    repeat (4 + LAT) step();

    // Departure: two cars retired on GREEN cycles 4 and 8
    car();
    check("dep_pre_count", queue_count, 2);
    country = GREEN;
    push(cyc + 4, 1'b0, 1'b1, 1, 1'b0);
    push(cyc + 8, 1'b0, 1'b1, 0, 1'b0);
    repeat (4) step();
    check("dep1_count", queue_count, 1);
    check("dep1_x", x, 1);
    repeat (4) step();
    check("dep2_count", queue_count, 0);
    check("dep2_x", x, 0);
    country = RED;
    m_cnt = 0;
    step();

    // Interrupted GREEN restarts the timer
    car();
    country = GREEN;
    repeat (3) step();
    country = YELLOW;
    step();
    country = GREEN;
    repeat (3) step();
    country = RED;
    step();
    check("restart_count", queue_count, 1);
    country = GREEN;
    push(cyc + 4, 1'b0, 1'b1, 0, 1'b0);
    repeat (4) step();
    country = RED;
    m_cnt = 0;
    step();

    // Simultaneous arrival and departure
    car();
    c0 = cyc;
    push(c0 + 5, 1'b1, 1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      loop_in = (k >= 2 - LAT);
      country = (k >= 1) ? GREEN : RED;
      step();
    end
    country = RED;
    loop_in = 1'b0;
    check("sim_count", queue_count, 1);
    repeat (4 + LAT) step();

    // Saturation: 16 arrivals from empty
    clear = 1'b0;
    step();
    clear = 1'b1;
    m_cnt = 0;
    m_ovf = 1'b0;
    check("rst2_count", queue_count, 0);
    repeat (15) car();
    check("sat15_count", queue_count, 15);
    check("sat15_overflow", overflow, 0);
    car();
    check("sat_count", queue_count, 15);
    check("sat_overflow", overflow, 1);

    // Invalid colour sets light_err and resets the timer
    check("lerr_pre", light_err, 0);
    country = GREEN;
    repeat (3) step();
    country = BAD;
    step();
    country = GREEN;
    repeat (3) step();
    country = RED;
    step();
    check("lerr", light_err, 1);
    check("lerr_count", queue_count, 15);

    // Drain to 5 cars
    country = GREEN;
    b = cyc;
    for (int k = 1; k <= 10; k++) begin
      m_cnt--;
      push(b + 4 * k, 1'b0, 1'b1, m_cnt, 1'b1);
    end
    repeat (40) step();
    country = RED;
    step();
    check("drain_count", queue_count, 5);
    check("drain_light_err", light_err, 1);

    // Mid-qualification reset with 5 queued
    loop_in = 1'b1;
    repeat (2 + LAT) step();
    clear = 1'b0;
    step();
    check_all_zero("midrst");
    clear = 1'b1;
    m_cnt = 1;
    m_ovf = 1'b0;
    push(cyc + 3 + LAT, 1'b1, 1'b0, 1, 1'b0);
    repeat (3 + LAT) step();
    check("post_rst_count", queue_count, 1);
    check("post_rst_x", x, 1);
    loop_in = 1'b0;
    repeat (4 + LAT) step();

    repeat (5) step();
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/country_vehicle_sensor.md
Name: country_vehicle_sensor

Overview:
- Vehicle-detection front end for the highway/country intersection; produces the country-road car-waiting input `x` consumed by the signal controller.
- Qualifies a raw inductive-loop input into discrete car arrivals and tracks the number of queued country-road cars.
- Retires queued cars while the country light is GREEN.
- Sits between the loop-detector pad and the signal controller; observes the controller's `country` light output.

Parameters:
- DEBOUNCE, 3, consecutive high (or low) samples of `loop_in` needed to qualify a car on (or off) the loop; legal range 1..15.
- MAX_CARS, 15, queue count saturation value; must fit in CNT_W.
- CNT_W, 4, width of `queue_count`.
- DEPART_CYCLES, 4, clock cycles of continuous country GREEN needed to retire one car; legal range 1..15.

Ports:
- clock, input, 1, system clock; all state changes on posedge.
- clear, input, 1, synchronous active-low reset.
- loop_in, input, 1, raw loop detector; 1 = metal present.
- country, input, 2, country light colour: 0 = RED, 1 = YELLOW, 2 = GREEN, 3 = invalid.
- x, output, 1, registered; 1 = at least one car queued; drives the controller's `x`.
- queue_count, output, CNT_W, registered count of queued cars.
- arrive, output, 1, one-cycle pulse when an arrival is counted.
- depart, output, 1, one-cycle pulse when a car is retired.
- overflow, output, 1, sticky; set when an arrival is dropped at saturation.
- light_err, output, 1, sticky; set when `country` is sampled equal to 3.

Behaviour:
- Reset: when `clear` = 0 at a posedge, all outputs become 0, the FSM enters IDLE, and the debounce counter and depart timer become 0. Reset overrides every other event in that cycle, including mid-qualification and mid-departure.
- Detector FSM states: IDLE, QUAL_ON, OCCUPIED, QUAL_OFF. The debounce counter counts qualifying samples.
  - IDLE: `loop_in` = 1 → QUAL_ON with cnt = 1; if DEBOUNCE = 1, go directly to OCCUPIED and count the arrival.
  - QUAL_ON: `loop_in` = 1 → cnt++; when cnt reaches DEBOUNCE, go to OCCUPIED and count the arrival on that edge. `loop_in` = 0 → IDLE, no arrival counted.
  - OCCUPIED: `loop_in` = 0 → QUAL_OFF with cnt = 1 (or IDLE directly if DEBOUNCE = 1).
  - QUAL_OFF: `loop_in` = 0 → cnt++; at DEBOUNCE → IDLE. `loop_in` = 1 → back to OCCUPIED.
  - A car held on the loop indefinitely counts exactly once.
- Arrival latency: the arrival is counted on the edge that samples the DEBOUNCE-th consecutive high. `arrive`, `queue_count` and `x` all update on that same edge.
- Departure timer:
  - The timer increments each cycle while `country` == GREEN and `queue_count` > 0.
  - When the timer reaches DEPART_CYCLES − 1: `depart` pulses, the count decrements, and the timer returns to 0.
  - The timer returns to 0 whenever `country` != GREEN or the count is 0. YELLOW, RED and invalid never retire cars.
- Count arithmetic:
  - Arrival and depart on the same edge: count unchanged; both pulses assert.
  - Arrival alone at MAX_CARS: count holds, `arrive` = 0, `overflow` is set.
  - Depart is never generated at count 0, so the count cannot underflow.
- `x` is registered as (next `queue_count` != 0). It deasserts on the same edge as the depart that takes the count to 0.
- Invalid colour (`country` == 3) is treated as RED and sets `light_err`. Only reset clears `overflow` and `light_err`.

Optional Feature:
- SENSOR_SYNC_EN
  - Defined: `loop_in` passes through a 2-flop synchronizer, reset to 0, before reaching the detector FSM. Arrival latency grows by exactly 2 cycles.
  - Undefined: `loop_in` is sampled directly; no added latency.

Test Plan:
- Reset then idle: hold `clear` = 0 for 2 cycles, then release with `loop_in` = 0 and `country` = RED for 10 cycles → all outputs stay 0.
- Debounce: `loop_in` high for 2 cycles then low → no arrive, count 0. Then high for 3 cycles → arrive pulses on the 3rd edge, `queue_count` = 1, `x` = 1; holding high for 20 more cycles → count stays 1.
- Departure: count = 2, drive `country` = GREEN → depart pulses at GREEN cycles 4 and 8, count goes 2→1→0, and `x` drops on the cycle-8 edge. A GREEN run of 3 cycles, then YELLOW, then GREEN restarts the timer with no depart.
- Simultaneous: count = 1, arrival qualifies on the same edge as the depart → both pulses assert and count stays 1.
- Saturation and error: 16 separated arrivals → count = 15 and `overflow` = 1 after the 16th. `country` = 3 for 1 cycle → `light_err` = 1 and the timer resets.
- Mid-operation reset: `clear` = 0 during QUAL_ON with count = 5 → next cycle count 0, `x` 0, FSM in IDLE. The same timing with SENSOR_SYNC_EN defined shows arrive 2 cycles later.
